// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants, digit layout and latch FSM states
package vga_pkg;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_BACK  = 48;
  localparam int H_VIS   = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int V_BACK  = 33;
  localparam int V_VIS   = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;

  // Counter origin is the start of back porch, so visible begins at the porch width.
  localparam int H_TOTAL      = H_BACK + H_VIS + H_FRONT + H_SYNC;
  localparam int H_VIS_START  = H_BACK;
  localparam int H_VIS_END    = H_BACK + H_VIS;
  localparam int H_SYNC_START = H_VIS_END + H_FRONT;
  localparam int V_TOTAL      = V_BACK + V_VIS + V_FRONT + V_SYNC;
  localparam int V_VIS_START  = V_BACK;
  localparam int V_VIS_END    = V_BACK + V_VIS;
  localparam int V_SYNC_START = V_VIS_END + V_FRONT;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 6;
  localparam int TIME_W     = DIGIT_W * NUM_DIGITS;
  localparam int DIG_S0 = 0;
  localparam int DIG_S1 = 1;
  localparam int DIG_M0 = 2;
  localparam int DIG_M1 = 3;
  localparam int DIG_H0 = 4;
  localparam int DIG_H1 = 5;

  typedef enum logic [1:0] {
    VIS  = 2'd0,
    OPEN = 2'd1,
    DONE = 2'd2
  } latch_state_e;

  function automatic logic all_bcd(input logic [TIME_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/vga_frame_ctrl_if.sv
// rtl/vga_frame_ctrl_if.sv - time digit handshake from the timekeeping core
interface vga_frame_ctrl_if;
  import vga_pkg::*;

  logic [TIME_W-1:0] time_in;
  logic              in_valid;
  logic              in_ready;

  modport master (output time_in, output in_valid, input in_ready);
  modport slave  (input time_in, input in_valid, output in_ready);
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - raster counters with registered syncs, video_on and frame_start
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_BACK  = vga_pkg::H_BACK,
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FRONT = vga_pkg::H_FRONT,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int V_BACK  = vga_pkg::V_BACK,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FRONT = vga_pkg::V_FRONT,
  parameter int V_SYNC  = vga_pkg::V_SYNC
) (
  input  logic clk,
  input  logic rst,
  output cnt_t count_h_o,
  output cnt_t count_v_o,
  output logic h_sinc_o,
  output logic v_sinc_o,
  output logic video_on_o,
  output logic frame_start_o,
  output logic blank_next_o
);

  localparam cnt_t H_LAST = cnt_t'(H_BACK + H_VIS + H_FRONT + H_SYNC - 1);
  localparam cnt_t H_VS   = cnt_t'(H_BACK);
  localparam cnt_t H_VE   = cnt_t'(H_BACK + H_VIS);
  localparam cnt_t H_SS   = cnt_t'(H_BACK + H_VIS + H_FRONT);
  localparam cnt_t V_LAST = cnt_t'(V_BACK + V_VIS + V_FRONT + V_SYNC - 1);
  localparam cnt_t V_VS   = cnt_t'(V_BACK);
  localparam cnt_t V_VE   = cnt_t'(V_BACK + V_VIS);
  localparam cnt_t V_SS   = cnt_t'(V_BACK + V_VIS + V_FRONT);

  cnt_t h_q, h_d, v_q, v_d;
  logic hs_q, vs_q, vid_q, fs_q;

  always_comb begin
    h_d = h_q + cnt_t'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
    end
  end

  // Decoding the next count keeps every output in the same cycle as the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      vid_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= !(h_d >= H_SS);
      vs_q  <= !(v_d >= V_SS);
      vid_q <= (h_d >= H_VS) && (h_d < H_VE) && (v_d >= V_VS) && (v_d < V_VE);
      fs_q  <= (h_d == '0) && (v_d == '0);
    end
  end

  assign blank_next_o  = (v_d < V_VS) || (v_d >= V_VE);
  assign count_h_o     = h_q;
  assign count_v_o     = v_q;
  assign h_sinc_o      = hs_q;
  assign v_sinc_o      = vs_q;
  assign video_on_o    = vid_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_frame_ctrl.sv
// rtl/vga_frame_ctrl.sv - raster plus blanking-only digit latch; TEST_PATTERN_EN adds test_en pattern mode
module vga_frame_ctrl
  import vga_pkg::*;
#(
  parameter int H_BACK  = vga_pkg::H_BACK,
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FRONT = vga_pkg::H_FRONT,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int V_BACK  = vga_pkg::V_BACK,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FRONT = vga_pkg::V_FRONT,
  parameter int V_SYNC  = vga_pkg::V_SYNC
) (
  input  logic         clk,
  input  logic         rst,
`ifdef TEST_PATTERN_EN
  input  logic         test_en,
`endif
  vga_frame_ctrl_if.slave tin,
  output logic         h_sinc,
  output logic         v_sinc,
  output cnt_t         countH,
  output cnt_t         countV,
  output logic         video_on,
  output logic         frame_start,
  output logic [DIGIT_W-1:0] h1,
  output logic [DIGIT_W-1:0] h0,
  output logic [DIGIT_W-1:0] m1,
  output logic [DIGIT_W-1:0] m0,
  output logic [DIGIT_W-1:0] s1,
  output logic [DIGIT_W-1:0] s0,
  output logic         bad_bcd
);

  logic blank_next;
  logic test_mode;

  vga_sync_gen #(
    .H_BACK(H_BACK), .H_VIS(H_VIS), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC),
    .V_BACK(V_BACK), .V_VIS(V_VIS), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC)
  ) u_sync (
    .clk           (clk),
    .rst           (rst),
    .count_h_o     (countH),
    .count_v_o     (countV),
    .h_sinc_o      (h_sinc),
    .v_sinc_o      (v_sinc),
    .video_on_o    (video_on),
    .frame_start_o (frame_start),
    .blank_next_o  (blank_next)
  );

`ifdef TEST_PATTERN_EN
  logic [5:0]         fcnt_q, fcnt_d;
  logic [DIGIT_W-1:0] pat_q, pat_d;

  assign test_mode = test_en;

  // Pattern digit advances once per 60 frames, i.e. roughly once a second.
  always_comb begin
    fcnt_d = fcnt_q;
    pat_d  = pat_q;
    if (frame_start) begin
      if (fcnt_q == 6'd59) begin
        fcnt_d = '0;
        pat_d  = (pat_q == 4'd9) ? '0 : pat_q + 4'd1;
      end else begin
        fcnt_d = fcnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
      pat_q  <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      pat_q  <= pat_d;
    end
  end
`else
  assign test_mode = 1'b0;
`endif

  latch_state_e      state_q, state_d;
  logic              in_ready_q;
  logic [TIME_W-1:0] digits_q, digits_d;
  logic              bad_q, bad_d;
  logic              accept, take;

  assign accept = tin.in_valid && in_ready_q && !test_mode;
  // Leaving blanking wins over a handshake offered in the same cycle.
  assign take   = accept && blank_next;

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    bad_d    = 1'b0;
    case (state_q)
      VIS:     if (blank_next) state_d = OPEN;
      OPEN:    if (!blank_next) state_d = VIS;
               else if (take) state_d = DONE;
      DONE:    if (!blank_next) state_d = VIS;
      default: state_d = VIS;
    endcase
    if (take) begin
      if (all_bcd(tin.time_in)) digits_d = tin.time_in;
      else bad_d = 1'b1;
    end
`ifdef TEST_PATTERN_EN
    if (test_en) digits_d = {NUM_DIGITS{pat_d}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OPEN;
      in_ready_q <= 1'b1;
      digits_q   <= '0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == OPEN) && !test_mode;
      digits_q   <= digits_d;
      bad_q      <= bad_d;
    end
  end

  assign tin.in_ready = in_ready_q;
  assign bad_bcd      = bad_q;
  assign h1 = digits_q[DIG_H1*DIGIT_W +: DIGIT_W];
  assign h0 = digits_q[DIG_H0*DIGIT_W +: DIGIT_W];
  assign m1 = digits_q[DIG_M1*DIGIT_W +: DIGIT_W];
  assign m0 = digits_q[DIG_M0*DIGIT_W +: DIGIT_W];
  assign s1 = digits_q[DIG_S1*DIGIT_W +: DIGIT_W];
  assign s0 = digits_q[DIG_S0*DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// tb/tb_vga_frame_ctrl.sv - directed bench: small-raster DUT plus full 640x480 DUT
module tb_vga_frame_ctrl;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Small raster: H 4/8/2/3 -> 17 clocks per line, V 3/5/2/2 -> 12 lines, 204 clocks per frame.
  localparam int SHT = 17;
  localparam int SFR = 204;

  vga_frame_ctrl_if sif ();
  vga_frame_ctrl_if dif ();

`ifdef TEST_PATTERN_EN
  logic test_en = 1'b0;
`endif

  logic s_hs, s_vs, s_vid, s_fs, s_bad;
  cnt_t s_ch, s_cv;
  logic [3:0] s_h1, s_h0, s_m1, s_m0, s_s1, s_s0;
  logic d_hs, d_vs, d_vid, d_fs, d_bad;
  cnt_t d_ch, d_cv;
  logic [3:0] d_h1, d_h0, d_m1, d_m0, d_s1, d_s0;

  wire [23:0] s_dig = {s_h1, s_h0, s_m1, s_m0, s_s1, s_s0};

  vga_frame_ctrl #(
    .H_BACK(4), .H_VIS(8), .H_FRONT(2), .H_SYNC(3),
    .V_BACK(3), .V_VIS(5), .V_FRONT(2), .V_SYNC(2)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .tin(sif.slave),
    .h_sinc(s_hs), .v_sinc(s_vs), .countH(s_ch), .countV(s_cv),
    .video_on(s_vid), .frame_start(s_fs),
    .h1(s_h1), .h0(s_h0), .m1(s_m1), .m0(s_m0), .s1(s_s1), .s0(s_s0),
    .bad_bcd(s_bad)
  );

  vga_frame_ctrl dut_full (
    .clk(clk), .rst(rst),
`ifdef TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .tin(dif.slave),
    .h_sinc(d_hs), .v_sinc(d_vs), .countH(d_ch), .countV(d_cv),
    .video_on(d_vid), .frame_start(d_fs),
    .h1(d_h1), .h0(d_h0), .m1(d_m1), .m0(d_m0), .s1(d_s1), .s0(d_s0),
    .bad_bcd(d_bad)
  );

  int errors = 0;
  int checks = 0;
  int t = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  initial begin
    int e_cnt_s, e_sync_s, e_vid_s, e_fs_s, e_rdy_s;
    int e_cnt_d, e_sync_d, e_vid_d, e_fs_d;
    int vid_s, vid_d, hsl_d;
    int h, v, t1, t2;
    e_cnt_s = 0; e_sync_s = 0; e_vid_s = 0; e_fs_s = 0; e_rdy_s = 0;
    e_cnt_d = 0; e_sync_d = 0; e_vid_d = 0; e_fs_d = 0;
    vid_s = 0; vid_d = 0; hsl_d = 0;
    sif.time_in = '0; sif.in_valid = 1'b0;
    dif.time_in = '0; dif.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_countH", 32'(s_ch), 0);
    check("rst_countV", 32'(s_cv), 0);
    check("rst_hsync", 32'(s_hs), 1);
    check("rst_vsync", 32'(s_vs), 1);
    check("rst_video_on", 32'(s_vid), 0);
    check("rst_frame_start", 32'(s_fs), 0);
    check("rst_in_ready", 32'(sif.in_ready), 1);
    check("rst_digits", 32'(s_dig), 0);
    check("rst_bad_bcd", 32'(s_bad), 0);

    rst = 1'b0;
    t = 0;
    for (int i = 0; i < 27200; i++) begin
      h = t % SHT;
      v = (t / SHT) % 12;
      if (32'(s_ch) != h || 32'(s_cv) != v) e_cnt_s++;
      if (s_hs !== !(h >= 14) || s_vs !== !(v >= 10)) e_sync_s++;
      if (s_vid !== (h >= 4 && h < 12 && v >= 3 && v < 8)) e_vid_s++;
      if (s_fs !== (t > 0 && h == 0 && v == 0)) e_fs_s++;
      if (sif.in_ready !== (v < 3 || v >= 8)) e_rdy_s++;
      if (s_vid === 1'b1) vid_s++;
      h = t % 800;
      v = (t / 800) % 525;
      if (32'(d_ch) != h || 32'(d_cv) != v) e_cnt_d++;
      if (d_hs !== !(h >= 704) || d_vs !== !(v >= 523)) e_sync_d++;
      if (d_vid !== (h >= 48 && h < 688 && v >= 33 && v < 513)) e_vid_d++;
      if (d_fs !== (t > 0 && h == 0 && v == 0)) e_fs_d++;
      if (d_vid === 1'b1) vid_d++;
      if (d_hs === 1'b0) hsl_d++;
      step();
    end
    check("small_counters", e_cnt_s, 0);
    check("small_syncs", e_sync_s, 0);
    check("small_video_on", e_vid_s, 0);
    check("small_frame_start", e_fs_s, 0);
    check("small_in_ready_idle", e_rdy_s, 0);
    check("small_video_cycles", vid_s, 133 * 40 + 8);
    check("full_counters", e_cnt_d, 0);
    check("full_syncs", e_sync_d, 0);
    check("full_video_on", e_vid_d, 0);
    check("full_frame_start", e_fs_d, 0);
    check("full_video_line33", vid_d, 640);
    check("full_hsync_low", hsl_d, 34 * 96);

    while (((t % SFR) / SHT) != 5) step();
    sif.time_in = 24'h123456;
    sif.in_valid = 1'b1;
    step();
    check("vis_ready_low", 32'(sif.in_ready), 0);
    for (int i = 0; i < 400; i++) begin
      if (sif.in_ready) break;
      step();
    end
    check("xfer1_ready", 32'(sif.in_ready), 1);
    check("xfer1_countV", 32'(s_cv), 8);
    check("xfer1_countH", 32'(s_ch), 0);
    t1 = t;
    step();
    check("xfer1_digits", 32'(s_dig), 32'h123456);
    check("xfer1_bad", 32'(s_bad), 0);
    check("xfer1_done_ready", 32'(sif.in_ready), 0);

    sif.time_in = 24'h000001;
    repeat (3) step();
    check("second_blocked_ready", 32'(sif.in_ready), 0);
    check("second_blocked_digits", 32'(s_dig), 32'h123456);
    for (int i = 0; i < 400; i++) begin
      if (sif.in_ready) break;
      step();
    end
    check("xfer2_ready", 32'(sif.in_ready), 1);
    check("xfer2_period", t - t1, SFR);
    check("xfer2_countV", 32'(s_cv), 8);
    t2 = t;
    step();
    check("xfer2_digits", 32'(s_dig), 32'h000001);

    sif.time_in = 24'h12A456;
    for (int i = 0; i < 400; i++) begin
      if (sif.in_ready) break;
      step();
    end
    check("xfer3_ready", 32'(sif.in_ready), 1);
    check("xfer3_period", t - t2, SFR);
    step();
    check("badbcd_pulse", 32'(s_bad), 1);
    check("badbcd_digits_hold", 32'(s_dig), 32'h000001);
    check("badbcd_done_ready", 32'(sif.in_ready), 0);
    step();
    check("badbcd_one_cycle", 32'(s_bad), 0);
    sif.in_valid = 1'b0;

    for (int i = 0; i < 400; i++) begin
      if (s_ch == cnt_t'(15) && s_cv == cnt_t'(10)) break;
      step();
    end
    check("prerst_countV", 32'(s_cv), 10);
    check("prerst_hsync", 32'(s_hs), 0);
    check("prerst_vsync", 32'(s_vs), 0);
    rst = 1'b1;
    step();
    check("midrst_countH", 32'(s_ch), 0);
    check("midrst_countV", 32'(s_cv), 0);
    check("midrst_hsync", 32'(s_hs), 1);
    check("midrst_vsync", 32'(s_vs), 1);
    check("midrst_digits", 32'(s_dig), 0);
    check("midrst_in_ready", 32'(sif.in_ready), 1);
    check("midrst_full_countV", 32'(d_cv), 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
